// File: rtl/imem_loader.sv
// Boot loader: holds the CPU in reset while it fills instruction RAM word by word
// from a byte stream, then releases the CPU once the requested word count is stored.
module imem_loader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
    logic [CNT_W-1:0]  tmo_q,      tmo_d;
    logic [31:0]       word_q,     word_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [LEN_W-1:0]  ww_d;
    logic              done_d, error_d, cpu_resetn_d;
    logic [1:0]        lane;

    // State decodes driven straight to the byte source and RAM port
    assign byte_ready = (state_q == S_LOAD);
    assign imem_we    = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);

    // Lane 0 is [7:0]; big-endian mode mirrors the byte index
    assign lane = (BIG_ENDIAN != 0) ? ~byte_idx_q : byte_idx_q;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        tmo_d      = tmo_q;
        word_d     = word_q;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        ww_d       = words_written;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    ww_d = '0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // Lengths above the RAM depth are clamped to a full fill
                        last_idx_d = len[ADDR_W] ? '1 : ADDR_W'(len - LEN_W'(1));
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        tmo_d      = '0;
                        word_d     = '0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    word_d[{lane, 3'b000} +: 8] = byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    tmo_d      = '0;
                    if (byte_idx_q == 2'd3) begin
                        addr_d  = word_idx_q;
                        wdata_d = word_d;
                        state_d = S_WRITE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                ww_d = words_written + LEN_W'(1);
                if (word_idx_q == last_idx_q) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    byte_idx_d = '0;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
        cpu_resetn_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            byte_idx_q    <= '0;
            word_idx_q    <= '0;
            last_idx_q    <= '0;
            tmo_q         <= '0;
            word_q        <= '0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            words_written <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_resetn    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            word_idx_q    <= word_idx_d;
            last_idx_q    <= last_idx_d;
            tmo_q         <= tmo_d;
            word_q        <= word_d;
            imem_addr     <= addr_d;
            imem_wdata    <= wdata_d;
            words_written <= ww_d;
            done          <= done_d;
            error         <= error_d;
            cpu_resetn    <= cpu_resetn_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: small RAM (ADDR_W=3) and short timeout (16).
module tb_imem_loader;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned TIMEOUT = 16;

    logic              clock;
    logic              resetn;
    logic              start;
    logic [ADDR_W:0]   len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_resetn;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_written;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    int acc_cyc    = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cyc[$];

    imem_loader #(
        .ADDR_W     (ADDR_W),
        .TIMEOUT    (TIMEOUT),
        .BIG_ENDIAN (0)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .len           (len),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_resetn    (cpu_resetn),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle id = value of cyc during that cycle; the RAM write log uses the same id
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic rdy;
        bit   got;
        got        = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            rdy = byte_ready;
            step();
            if (rdy) got = 1'b1;
        end
        byte_valid = 1'b0;
        acc_cyc    = cyc - 1;
        if (!got) begin
            assertions++;
            failures++;
            $display("FAIL push_byte: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        assertions++;
        if ({done, error, cpu_resetn, byte_ready, imem_we, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {done, error, cpu_resetn, byte_ready, imem_we, busy});
        end
        assertions++;
        if ({imem_addr, imem_wdata, words_written} !== '0) begin
            failures++;
            $display("FAIL reset_regs: addr %h data %h ww %h expected all 0",
                     imem_addr, imem_wdata, words_written);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[8] = '{8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00};
        int c0;
        clear_log();
        do_start(4'd2);
        assertions++;
        if (busy !== 1'b1 || cpu_resetn !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy: busy %b cpu_resetn %b expected 1 0", busy, cpu_resetn);
        end
        push_byte(b[0]);
        c0 = acc_cyc;
        for (int i = 1; i < 8; i++) push_byte(b[i]);
        assertions++;
        if (done !== 1'b0 || cyc - c0 != 9) begin
            failures++;
            $display("FAIL b2b_pre_done: done %b cycle %0d expected 0 at cycle 9", done, cyc - c0);
        end
        step();
        assertions++;
        if (done !== 1'b1 || cpu_resetn !== 1'b1 || cyc - c0 != 10) begin
            failures++;
            $display("FAIL b2b_done: done %b cpu_resetn %b cycle %0d expected 1 1 at cycle 10",
                     done, cpu_resetn, cyc - c0);
        end
        assertions++;
        if (words_written !== 4'd2) begin
            failures++;
            $display("FAIL b2b_ww: got %0d expected 2", words_written);
        end
        assertions++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL b2b_nwrites: got %0d expected 2", wr_addr.size());
        end else if (wr_addr[0] !== 3'd0 || wr_data[0] !== 32'h20000013 ||
                     wr_addr[1] !== 3'd1 || wr_data[1] !== 32'h00000008) begin
            failures++;
            $display("FAIL b2b_writes: got %h:%h %h:%h expected 0:20000013 1:00000008",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] pat[6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        int k;
        int acc4;
        logic exp_rdy;
        clear_log();
        k    = 0;
        acc4 = -100;
        do_start(4'd1);
        for (int i = 0; i < 12; i++) begin
            byte_valid = (i % 2 == 0);
            byte_in    = pat[k];
            exp_rdy    = (i <= 6);
            assertions++;
            if (byte_ready !== exp_rdy) begin
                failures++;
                $display("FAIL toggle_ready[%0d]: got %b expected %b", i, byte_ready, exp_rdy);
            end
            if (byte_valid && byte_ready) begin
                if (k == 3) acc4 = cyc;
                k++;
            end
            step();
        end
        byte_valid = 1'b0;
        assertions++;
        if (k != 4 || done !== 1'b1) begin
            failures++;
            $display("FAIL toggle_accepts: accepted %0d done %b expected 4 1", k, done);
        end
        assertions++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL toggle_nwrites: got %0d expected 1", wr_addr.size());
        end else if (wr_addr[0] !== 3'd0 || wr_data[0] !== 32'hDDCCBBAA ||
                     wr_cyc[0] != acc4 + 1) begin
            failures++;
            $display("FAIL toggle_write: got %h:%h at +%0d expected 0:ddccbbaa at +1",
                     wr_addr[0], wr_data[0], wr_cyc[0] - acc4);
        end
    endtask

    task automatic test_timeout();
        logic exp_err;
        clear_log();
        do_start(4'd1);
        push_byte(8'h55);
        push_byte(8'h66);
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_err = (j == 16);
            assertions++;
            if (error !== exp_err) begin
                failures++;
                $display("FAIL timeout_err[%0d]: got %b expected %b", j, error, exp_err);
            end
        end
        assertions++;
        if (cpu_resetn !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL timeout_state: cpu_resetn %b busy %b ready %b writes %0d expected 0 0 0 0",
                     cpu_resetn, busy, byte_ready, wr_addr.size());
        end
        do_start(4'd1);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        step();
        assertions++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_resetn !== 1'b1 || words_written !== 4'd1) begin
            failures++;
            $display("FAIL retry_done: done %b error %b cpu_resetn %b ww %0d expected 1 0 1 1",
                     done, error, cpu_resetn, words_written);
        end
        assertions++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL retry_nwrites: got %0d expected 1", wr_addr.size());
        end else if (wr_addr[0] !== 3'd0 || wr_data[0] !== 32'h44332211) begin
            failures++;
            $display("FAIL retry_write: got %h:%h expected 0:44332211", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_len_zero();
        clear_log();
        do_start(4'd0);
        assertions++;
        if (done !== 1'b1 || busy !== 1'b0 || words_written !== 4'd0) begin
            failures++;
            $display("FAIL len0_done: done %b busy %b ww %0d expected 1 0 0", done, busy, words_written);
        end
        step();
        step();
        assertions++;
        if (wr_addr.size() != 0 || cpu_resetn !== 1'b1) begin
            failures++;
            $display("FAIL len0_writes: writes %0d cpu_resetn %b expected 0 1", wr_addr.size(), cpu_resetn);
        end
    endtask

    task automatic test_reload();
        clear_log();
        assertions++;
        if (cpu_resetn !== 1'b1) begin
            failures++;
            $display("FAIL reload_pre: cpu_resetn got %b expected 1", cpu_resetn);
        end
        do_start(4'd1);
        assertions++;
        if (cpu_resetn !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reload_hold: cpu_resetn %b busy %b done %b expected 0 1 0", cpu_resetn, busy, done);
        end
        push_byte(8'hEF);
        push_byte(8'hBE);
        push_byte(8'hAD);
        push_byte(8'hDE);
        assertions++;
        if (imem_we !== 1'b1 || imem_addr !== 3'd0 || imem_wdata !== 32'hDEADBEEF || cpu_resetn !== 1'b0) begin
            failures++;
            $display("FAIL reload_write: we %b addr %h data %h cpu_resetn %b expected 1 0 deadbeef 0",
                     imem_we, imem_addr, imem_wdata, cpu_resetn);
        end
        step();
        assertions++;
        if (cpu_resetn !== 1'b1 || done !== 1'b1 || words_written !== 4'd1) begin
            failures++;
            $display("FAIL reload_release: cpu_resetn %b done %b ww %0d expected 1 1 1",
                     cpu_resetn, done, words_written);
        end
    endtask

    task automatic test_midload_reset();
        clear_log();
        do_start(4'd2);
        for (int i = 1; i <= 6; i++) push_byte(8'(i));
        resetn = 1'b0;
        #1;
        assertions++;
        if ({done, error, cpu_resetn, byte_ready, imem_we, busy} !== 6'b0 ||
            {imem_addr, imem_wdata, words_written} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: flags %b addr %h data %h ww %h expected all 0",
                     {done, error, cpu_resetn, byte_ready, imem_we, busy},
                     imem_addr, imem_wdata, words_written);
        end
        step();
        resetn     = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h77;
        for (int i = 0; i < 4; i++) step();
        byte_valid = 1'b0;
        assertions++;
        if (byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle: ready %b busy %b done %b expected 0 0 0", byte_ready, busy, done);
        end
        assertions++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL midreset_nwrites: got %0d expected 1", wr_addr.size());
        end else if (wr_addr[0] !== 3'd0 || wr_data[0] !== 32'h04030201) begin
            failures++;
            $display("FAIL midreset_write: got %h:%h expected 0:04030201", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] exp_w;
        logic [7:0]  b0;
        clear_log();
        do_start(4'd12);
        for (int i = 0; i < 32; i++) push_byte(8'(i));
        step();
        assertions++;
        if (done !== 1'b1 || words_written !== 4'd8) begin
            failures++;
            $display("FAIL clamp_done: done %b ww %0d expected 1 8", done, words_written);
        end
        assertions++;
        if (wr_addr.size() != 8) begin
            failures++;
            $display("FAIL clamp_nwrites: got %0d expected 8", wr_addr.size());
        end else begin
            for (int n = 0; n < 8; n++) begin
                b0    = 8'(4 * n);
                exp_w = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
                assertions++;
                if (wr_addr[n] !== 3'(n) || wr_data[n] !== exp_w) begin
                    failures++;
                    $display("FAIL clamp_write[%0d]: got %h:%h expected %h:%h",
                             n, wr_addr[n], wr_data[n], 3'(n), exp_w);
                end
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        len        = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        #1;
        test_reset();
        test_back_to_back();
        test_toggle_valid();
        test_timeout();
        test_len_zero();
        test_reload();
        test_midload_reset();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
